// File: rtl/bit_width_expander_pkg.sv
// Shared helpers and state encoding for the narrow-to-wide word gatherer.
package bit_width_expander_pkg;

  // Number of bits needed to hold 'value' (at least one).
  function automatic int unsigned clogb2(input int unsigned value);
    int unsigned v;
    int unsigned n;
    v = value;
    n = 0;
    while (v > 0) begin
      n++;
      v = v >> 1;
    end
    return (n == 0) ? 1 : n;
  endfunction

  function automatic int unsigned calc_ratio(input int unsigned dout_width,
                                             input int unsigned din_width);
    return dout_width / din_width;
  endfunction

  function automatic int unsigned scnt_width(input int unsigned ratio);
    return clogb2(ratio - 1);
  endfunction

  typedef enum logic {
    StFill = 1'b0,
    StHold = 1'b1
  } state_e;

endpackage

// File: rtl/bit_width_expander_out_stage.sv
// Output holding register: loads an assembled word and keeps it stable until the downstream takes it.
module bit_width_expander_out_stage
  import bit_width_expander_pkg::*;
#(
  parameter int unsigned DOUT_WIDTH = 64,
  parameter int unsigned RATIO      = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic [DOUT_WIDTH-1:0] load_data,
  input  logic [RATIO-1:0]      load_keep,
  input  logic                  load_last,
  input  logic                  dout_ready,
  output logic [DOUT_WIDTH-1:0] dout,
  output logic                  dout_valid,
  output logic [RATIO-1:0]      dout_keep,
  output logic                  dout_last
);

  state_e                state_q, state_d;
  logic [DOUT_WIDTH-1:0] data_q;
  logic [RATIO-1:0]      keep_q;
  logic                  last_q;

  // A load only arrives when the register is empty or draining, so HOLD is left only on a bare drain.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StFill: if (load) state_d = StHold;
      StHold: if (dout_ready && !load) state_d = StFill;
      default: state_d = StFill;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StFill;
      data_q  <= '0;
      keep_q  <= '0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (load) begin
        data_q <= load_data;
        keep_q <= load_keep;
        last_q <= load_last;
      end
    end
  end

  assign dout       = data_q;
  assign dout_valid = (state_q == StHold);
  assign dout_keep  = keep_q;
  assign dout_last  = last_q;

endmodule

// File: rtl/bit_width_expander.sv
// Gathers DIN_WIDTH beats into DOUT_WIDTH words, first beat in the MSB slice; DIN_LAST flushes a
// zero-padded partial word with a per-slice keep mask.
module bit_width_expander
  import bit_width_expander_pkg::*;
#(
  parameter int unsigned DIN_WIDTH  = 16,
  parameter int unsigned DOUT_WIDTH = 64,
  localparam int unsigned RATIO     = calc_ratio(DOUT_WIDTH, DIN_WIDTH)
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic [DIN_WIDTH-1:0]  DIN,
  input  logic                  DIN_VALID,
  input  logic                  DIN_LAST,
  output logic                  DIN_READY,
  output logic [DOUT_WIDTH-1:0] DOUT,
  output logic                  DOUT_VALID,
  output logic                  DOUT_LAST,
  output logic [RATIO-1:0]      DOUT_KEEP,
  input  logic                  DOUT_READY
);

  localparam int unsigned SCNT_W = scnt_width(RATIO);
  localparam int unsigned ACC_W  = (RATIO - 1) * DIN_WIDTH;

  if ((DOUT_WIDTH % DIN_WIDTH) != 0 || RATIO < 2) begin : gen_param_check
    $error("DOUT_WIDTH must be a multiple of DIN_WIDTH with a ratio of at least 2");
  end

  logic [SCNT_W-1:0]     scnt_q, scnt_d;
  // Holds DOUT slices RATIO-1 down to 1; the last slice always comes straight from DIN.
  logic [ACC_W-1:0]      acc_q, acc_d;
  logic [DOUT_WIDTH-1:0] word_d;
  logic [RATIO-1:0]      keep_d;
  logic                  scnt_last;
  logic                  pending;
  logic                  accept;
  logic                  complete;
  int unsigned           slot;

  assign scnt_last = (scnt_q == SCNT_W'(RATIO - 1));
  assign pending   = scnt_last || (DIN_VALID && DIN_LAST);
  // Only a completing beat needs room in the output register.
  assign DIN_READY = !RESET && !(pending && DOUT_VALID && !DOUT_READY);
  assign accept    = DIN_VALID && DIN_READY;
  assign complete  = accept && pending;

  always_comb begin
    slot   = (RATIO - 1) - 32'(scnt_q);
    word_d = {acc_q, {DIN_WIDTH{1'b0}}};
    keep_d = '0;
    acc_d  = acc_q;
    scnt_d = scnt_q;
    for (int unsigned i = 0; i < RATIO; i++) begin
      if (i == slot) word_d[i*DIN_WIDTH +: DIN_WIDTH] = DIN;
      keep_d[i] = (i >= slot);
    end
    if (accept) begin
      if (complete) begin
        acc_d  = '0;
        scnt_d = '0;
      end else begin
        for (int unsigned j = 0; j < RATIO - 1; j++) begin
          if (j + 1 == slot) acc_d[j*DIN_WIDTH +: DIN_WIDTH] = DIN;
        end
        scnt_d = scnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      scnt_q <= '0;
      acc_q  <= '0;
    end else begin
      scnt_q <= scnt_d;
      acc_q  <= acc_d;
    end
  end

  bit_width_expander_out_stage #(
    .DOUT_WIDTH (DOUT_WIDTH),
    .RATIO      (RATIO)
  ) u_out_stage (
    .clk        (CLK),
    .reset      (RESET),
    .load       (complete),
    .load_data  (word_d),
    .load_keep  (keep_d),
    .load_last  (DIN_LAST),
    .dout_ready (DOUT_READY),
    .dout       (DOUT),
    .dout_valid (DOUT_VALID),
    .dout_keep  (DOUT_KEEP),
    .dout_last  (DOUT_LAST)
  );

endmodule

// File: tb/tb_bit_width_expander.sv
// Bench for bit_width_expander: directed cases plus a frame-level scoreboard on every handshake.
module tb_bit_width_expander;

  localparam int unsigned DW = 16;
  localparam int unsigned OW = 64;
  localparam int unsigned R  = OW / DW;

  logic          CLK = 1'b0;
  logic          RESET;
  logic [DW-1:0] DIN;
  logic          DIN_VALID;
  logic          DIN_LAST;
  logic          DIN_READY;
  logic [OW-1:0] DOUT;
  logic          DOUT_VALID;
  logic          DOUT_LAST;
  logic [R-1:0]  DOUT_KEEP;
  logic          DOUT_READY;

  always #5 CLK = ~CLK;

  bit_width_expander #(
    .DIN_WIDTH  (DW),
    .DOUT_WIDTH (OW)
  ) dut (
    .CLK        (CLK),
    .RESET      (RESET),
    .DIN        (DIN),
    .DIN_VALID  (DIN_VALID),
    .DIN_LAST   (DIN_LAST),
    .DIN_READY  (DIN_READY),
    .DOUT       (DOUT),
    .DOUT_VALID (DOUT_VALID),
    .DOUT_LAST  (DOUT_LAST),
    .DOUT_KEEP  (DOUT_KEEP),
    .DOUT_READY (DOUT_READY)
  );

  typedef struct {
    logic [OW-1:0] data;
    logic [R-1:0]  keep;
    logic          last;
  } word_t;

  word_t         exp_q[$];
  logic [DW-1:0] beats[$];
  int            n_checks = 0;
  int            n_pass   = 0;
  bit            mon_en   = 1'b0;
  int unsigned   cyc = 0, n_words = 0, n_valid_cyc = 0, n_ready_drop = 0;

  task automatic check(input string tag, input logic [OW-1:0] got, input logic [OW-1:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  always @(posedge CLK) cyc <= cyc + 1;

  // Reference model: beats of a frame concatenate MSB-first; a word closes after R beats or DIN_LAST.
  bit    m_pend;
  word_t m_w;
  int    m_n;
  always @(negedge CLK) begin
    if (mon_en) begin
      check("dout_valid", 64'(DOUT_VALID), 64'(exp_q.size() != 0));
      if (RESET) begin
        check("din_ready_in_reset", 64'(DIN_READY), 64'd0);
        exp_q.delete();
        beats.delete();
      end else begin
        m_pend = (beats.size() == R - 1) || (DIN_VALID && DIN_LAST);
        check("din_ready", 64'(DIN_READY), 64'(!(m_pend && exp_q.size() != 0 && !DOUT_READY)));
        if (DOUT_VALID) n_valid_cyc++;
        if (DIN_VALID && !DIN_READY) n_ready_drop++;
        if (DOUT_VALID && DOUT_READY) begin
          n_words++;
          if (exp_q.size() == 0) begin
            check("spurious_word", 64'd1, 64'd0);
          end else begin
            m_w = exp_q.pop_front();
            check("dout", DOUT, m_w.data);
            check("dout_keep", 64'(DOUT_KEEP), 64'(m_w.keep));
            check("dout_last", 64'(DOUT_LAST), 64'(m_w.last));
          end
        end
        if (DIN_VALID && DIN_READY) begin
          beats.push_back(DIN);
          if (beats.size() == R || DIN_LAST) begin
            m_n = beats.size();
            m_w.data = '0;
            for (int k = 0; k < m_n; k++) m_w.data |= 64'(beats[k]) << (OW - DW * (k + 1));
            m_w.keep = R'(((1 << m_n) - 1) << (R - m_n));
            m_w.last = DIN_LAST;
            exp_q.push_back(m_w);
            beats.delete();
          end
        end
      end
    end
  end

  task automatic send(input logic [DW-1:0] d, input logic l);
    DIN       = d;
    DIN_VALID = 1'b1;
    DIN_LAST  = l;
    for (int c = 0; c <= 100; c++) begin
      @(negedge CLK);
      if (DIN_READY) break;
      if (c == 100) check("send_timeout", 64'd1, 64'd0);
    end
    @(posedge CLK);
    #1;
    DIN_VALID = 1'b0;
    DIN       = 'x;
    DIN_LAST  = 1'b0;
  endtask

  task automatic idle(input int n);
    DIN_VALID = 1'b0;
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic check_word(input string tag, input logic [OW-1:0] d, input logic [R-1:0] k,
                            input logic l);
    check({tag, "_valid"}, 64'(DOUT_VALID), 64'd1);
    check({tag, "_data"}, DOUT, d);
    check({tag, "_keep"}, 64'(DOUT_KEEP), 64'(k));
    check({tag, "_last"}, 64'(DOUT_LAST), 64'(l));
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, got no end expected end");
    $fatal(1);
  end

  logic [DW-1:0] wb [4];
  int            idx, w0, v0, d0, c0;
  bit            rdy, stable, rdy_prev;

  initial begin
    RESET      = 1'b1;
    DIN        = '0;
    DIN_VALID  = 1'b0;
    DIN_LAST   = 1'b0;
    DOUT_READY = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    check("rst_dout", DOUT, 64'd0);
    check("rst_dout_valid", 64'(DOUT_VALID), 64'd0);
    check("rst_dout_keep", 64'(DOUT_KEEP), 64'd0);
    check("rst_dout_last", 64'(DOUT_LAST), 64'd0);
    check("rst_din_ready", 64'(DIN_READY), 64'd0);
    RESET  = 1'b0;
    mon_en = 1'b1;
    idle(1);

    // Contiguous full word
    DOUT_READY = 1'b1;
    send(16'hFFFF, 1'b0);
    send(16'h0000, 1'b0);
    send(16'h3232, 1'b0);
    send(16'h0404, 1'b0);
    check_word("contig", 64'hFFFF_0000_3232_0404, 4'b1111, 1'b0);
    idle(2);

    // Sustained throughput
    w0 = n_words; v0 = n_valid_cyc; d0 = n_ready_drop; c0 = cyc;
    for (int i = 0; i < 500; i++) send(16'($urandom), 1'b0);
    check("tput_cycles", 64'(cyc - c0), 64'd500);
    @(posedge CLK);
    #1;
    check("tput_words", 64'(n_words - w0), 64'd125);
    check("tput_valid_cycles", 64'(n_valid_cyc - v0), 64'd125);
    check("tput_ready_drops", 64'(n_ready_drop - d0), 64'd0);
    idle(2);

    // Partial word flushes, then next word restarts at the MSB slice
    send(16'hAAAA, 1'b0);
    send(16'hBBBB, 1'b1);
    check_word("last2", 64'hAAAA_BBBB_0000_0000, 4'b1100, 1'b1);
    send(16'h1111, 1'b0);
    send(16'h2222, 1'b0);
    send(16'h3333, 1'b0);
    send(16'h4444, 1'b0);
    check_word("restart", 64'h1111_2222_3333_4444, 4'b1111, 1'b0);
    send(16'h9999, 1'b1);
    check_word("last1", 64'h9999_0000_0000_0000, 4'b1000, 1'b1);
    send(16'h0A0A, 1'b0);
    send(16'h0B0B, 1'b0);
    send(16'h0C0C, 1'b0);
    send(16'h0D0D, 1'b1);
    check_word("last4", 64'h0A0A_0B0B_0C0C_0D0D, 4'b1111, 1'b1);
    idle(2);

    // Back-pressure: hold first word, fill three slices, stall on the fourth
    DOUT_READY = 1'b0;
    send(16'h1234, 1'b0);
    send(16'h5678, 1'b0);
    send(16'h9ABC, 1'b0);
    send(16'hDEF0, 1'b0);
    wb[0] = 16'h0102; wb[1] = 16'h0304; wb[2] = 16'h0506; wb[3] = 16'h0708;
    idx = 0;
    stable = 1'b1;
    rdy = 1'b0;
    for (int c = 0; c < 10; c++) begin
      DIN = wb[idx]; DIN_VALID = 1'b1; DIN_LAST = 1'b0;
      @(negedge CLK);
      rdy = DIN_READY;
      @(posedge CLK);
      #1;
      if (rdy) idx++;
      if (DOUT !== 64'h1234_5678_9ABC_DEF0 || DOUT_VALID !== 1'b1) stable = 1'b0;
    end
    check("bp_beats_accepted", 64'(idx), 64'd3);
    check("bp_stall_ready", 64'(rdy), 64'd0);
    check("bp_hold_stable", 64'(stable), 64'd1);
    DOUT_READY = 1'b1;
    @(negedge CLK);
    rdy = DIN_READY;
    @(posedge CLK);
    #1;
    check("bp_release_ready", 64'(rdy), 64'd1);
    check_word("bp_b2b", 64'h0102_0304_0506_0708, 4'b1111, 1'b0);
    DIN_VALID = 1'b0; DIN = 'x;
    @(posedge CLK);
    #1;
    check("bp_drained", 64'(DOUT_VALID), 64'd0);
    idle(1);

    // Reset mid-HOLD with a partial word behind it
    DOUT_READY = 1'b0;
    send(16'hE1E1, 1'b0);
    send(16'hE2E2, 1'b0);
    send(16'hE3E3, 1'b0);
    send(16'hE4E4, 1'b0);
    send(16'hCCCC, 1'b0);
    send(16'hDDDD, 1'b0);
    RESET = 1'b1; DIN = 16'hBEEF; DIN_VALID = 1'b1;
    @(negedge CLK);
    check("rst2_din_ready", 64'(DIN_READY), 64'd0);
    @(posedge CLK);
    #1;
    check("rst2_dout", DOUT, 64'd0);
    check("rst2_dout_valid", 64'(DOUT_VALID), 64'd0);
    check("rst2_dout_keep", 64'(DOUT_KEEP), 64'd0);
    check("rst2_dout_last", 64'(DOUT_LAST), 64'd0);
    RESET = 1'b0; DIN_VALID = 1'b0; DIN = 'x;
    DOUT_READY = 1'b1;
    idle(1);
    send(16'h5555, 1'b0);
    send(16'h6666, 1'b0);
    send(16'h7777, 1'b0);
    send(16'h8888, 1'b0);
    check_word("fresh", 64'h5555_6666_7777_8888, 4'b1111, 1'b0);
    idle(2);

    // Toggling valid with random back-pressure against the scoreboard
    w0 = n_words;
    rdy_prev = 1'b0;
    for (int c = 0; c < 400; c++) begin
      DOUT_READY = 1'($urandom_range(0, 1));
      if (!(DIN_VALID && !rdy_prev)) begin
        if (DIN_VALID) begin
          DIN_VALID = 1'b0; DIN = 'x; DIN_LAST = 1'b0;
        end else begin
          DIN_VALID = 1'b1;
          DIN       = 16'($urandom);
          DIN_LAST  = ($urandom_range(0, 7) == 0);
        end
      end
      @(negedge CLK);
      rdy_prev = DIN_READY;
      @(posedge CLK);
      #1;
    end
    DIN_VALID = 1'b0; DIN_LAST = 1'b0; DOUT_READY = 1'b1;
    idle(4);
    check("rand_drained", 64'(exp_q.size()), 64'd0);
    check("rand_words_seen", 64'(n_words - w0 > 10), 64'd1);

    mon_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
